// File: rtl/fa_bist.sv
// fa_bist: self-test controller for a single-bit full adder. Sweeps {a,b,c} over
// all eight vectors, checks sum/carry against the golden function and holds the verdict.
module fa_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

  function automatic logic golden_sum(input logic [2:0] v);
    return v[2] ^ v[1] ^ v[0];
  endfunction

  function automatic logic golden_carry(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  state_t           state_r, state_s;
  logic [2:0]       v_r, v_s;
  logic [2:0]       abc_r, abc_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic             fv_r, fv_s;
  logic [2:0]       fvec_r, fvec_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             mismatch_s;

  // Next-state logic, datapath updates and precompute of the registered status outputs
  always_comb begin
    state_s    = state_r;
    v_s        = v_r;
    abc_s      = abc_r;
    cnt_s      = cnt_r;
    err_s      = err_r;
    fv_s       = fv_r;
    fvec_s     = fvec_r;
    mismatch_s = (sum != golden_sum(v_r)) | (carry != golden_carry(v_r));

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = APPLY;
          v_s     = 3'd0;
          abc_s   = 3'd0;
          err_s   = ERR_ZERO;
          fv_s    = 1'b0;
          fvec_s  = 3'd0;
        end else begin
          state_s = state_r;
        end
      end
      APPLY: begin
        cnt_s   = SETTLE_L;
        state_s = SETTLE;
      end
      SETTLE: begin
        if (cnt_r <= 4'd1) begin
          state_s = CHECK;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      CHECK: begin
        // Only the first failing vector is captured; the counter sticks at its maximum
        if (mismatch_s) begin
          if (err_r != ERR_MAX) begin
            err_s = err_r + ERR_ONE;
          end else begin
            err_s = err_r;
          end
          if (!fv_r) begin
            fv_s   = 1'b1;
            fvec_s = v_r;
          end else begin
            fv_s = fv_r;
          end
        end else begin
          err_s = err_r;
        end
        if (v_r == 3'd7) begin
          state_s = DONE;
          abc_s   = 3'd0;
        end else begin
          state_s = APPLY;
          v_s     = v_r + 3'd1;
          abc_s   = v_r + 3'd1;
        end
      end
      default: begin
        state_s = IDLE;
        abc_s   = 3'd0;
      end
    endcase

    busy_s = (state_s == APPLY) || (state_s == SETTLE) || (state_s == CHECK);
    done_s = (state_s == DONE);
    pass_s = done_s && (err_s == ERR_ZERO);
  end

  // State, datapath and output registers; reset clears every result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      v_r     <= 3'd0;
      abc_r   <= 3'd0;
      cnt_r   <= 4'd0;
      err_r   <= ERR_ZERO;
      fv_r    <= 1'b0;
      fvec_r  <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      v_r     <= v_s;
      abc_r   <= abc_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      fv_r    <= fv_s;
      fvec_r  <= fvec_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  assign a          = abc_r[2];
  assign b          = abc_r[1];
  assign c          = abc_r[0];
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign fail_valid = fv_r;
  assign fail_vec   = fvec_r;

endmodule
